// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, response and memory-side signals of dmem_arbiter.
// req_lock is present only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [NUM_REQ-1:0]        req_valid, req_we, req_ready, rsp_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*3-1:0]      req_mask;
    logic [DATA_W-1:0]         rsp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic [2:0]                mem_mask;
    logic                      mem_wr_en, mem_rd_en, busy;
    logic [IW-1:0]             grant_id;
`ifdef DMEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif
    modport slave (
`ifdef DMEM_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_we, req_addr, req_wdata, req_mask, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_mask,
               mem_wr_en, mem_rd_en, busy, grant_id
    );
    modport master (
`ifdef DMEM_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_we, req_addr, req_wdata, req_mask, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_mask,
               mem_wr_en, mem_rd_en, busy, grant_id
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one data memory port among NUM_REQ requesters.
// Define DMEM_ARB_LOCK_EN to let a winner keep exclusive access through req_lock.
module dmem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
    logic [1:0]         r_state;
    logic [IW-1:0]      r_ptr, r_gid;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata, r_rdata;
    logic [2:0]         r_mask;
    logic [NUM_REQ-1:0] w_cand;
    logic [IW-1:0]      w_win;
    logic               w_found, w_locked, w_idle, w_access, w_resp;
`ifdef DMEM_ARB_LOCK_EN
    logic r_lock;
    assign w_locked = r_lock && bus.req_lock[r_gid];
    always_ff @(posedge clk) begin
        if (reset)
            r_lock <= 1'b0;
        else if (r_state == RESP)
            r_lock <= bus.req_lock[r_gid];
        else if (r_state == IDLE && !bus.req_lock[r_gid])
            r_lock <= 1'b0;
    end
`else
    assign w_locked = 1'b0;
`endif
    assign w_cand = w_locked ? (bus.req_valid & (NUM_REQ'(1) << r_gid)) : bus.req_valid;
    // Scan downward so the lowest offset from the pointer is the last, winning assignment.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (w_cand[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_ptr) + k) % NUM_REQ);
            end
    end
    assign w_idle   = !reset && r_state == IDLE;
    assign w_access = !reset && r_state == ACCESS;
    assign w_resp   = !reset && r_state == RESP;
    assign bus.req_ready = (w_idle && w_found) ? NUM_REQ'(1) << w_win : '0;
    assign bus.rsp_valid = w_resp ? NUM_REQ'(1) << r_gid : '0;
    assign bus.rsp_rdata = w_resp ? r_rdata : '0;
    assign bus.mem_addr  = w_access ? r_addr : '0;
    assign bus.mem_wdata = w_access ? r_wdata : '0;
    assign bus.mem_mask  = w_access ? r_mask : '0;
    assign bus.mem_wr_en = w_access && r_we;
    assign bus.mem_rd_en = w_access && !r_we;
    assign bus.busy      = r_state != IDLE;
    assign bus.grant_id  = r_gid;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_state <= ACCESS;
                    r_gid   <= w_win;
                    r_we    <= bus.req_we[w_win];
                    r_addr  <= bus.req_addr[w_win*ADDR_W +: ADDR_W];
                    r_wdata <= bus.req_wdata[w_win*DATA_W +: DATA_W];
                    r_mask  <= bus.req_mask[w_win*3 +: 3];
                    if (!w_locked)
                        r_ptr <= IW'((int'(w_win) + 1) % NUM_REQ);
                end
                ACCESS: begin
                    r_rdata <= r_we ? '0 : bus.mem_rdata;
                    r_state <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random traffic through dmem_arbiter with a byte-lane memory,
// checked cycle by cycle against a transaction-level model of arbitration and memory contents.
module tb_dmem_arbiter;
    localparam int NR = 3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    dmem_arbiter_if #(.NUM_REQ(NR)) bus ();
    dmem_arbiter #(.NUM_REQ(NR)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [2:0]  lm [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int total = 0, bad = 0;
    int ph = -1, ptr = 0, gid = 0;
    bit lk = 1'b0;
    bit c_we;
    logic [31:0] c_addr, c_wd, exp_rd, last_rd;
    logic [2:0]  c_mask;
    logic [NR-1:0] seen = '0;
    int obs[$];

    function automatic logic [31:0] ld(input logic [31:0] w, input logic [1:0] off, input logic [2:0] m);
        logic [31:0] s;
        s = w >> (8 * off);
        case (m)
            3'b000:  ld = {{24{s[7]}}, s[7:0]};
            3'b001:  ld = {{16{s[15]}}, s[15:0]};
            3'b100:  ld = {24'h0, s[7:0]};
            3'b101:  ld = {16'h0, s[15:0]};
            default: ld = s;
        endcase
    endfunction

    function automatic logic [31:0] st(input logic [31:0] w, input logic [31:0] d, input logic [1:0] off, input logic [2:0] m);
        int n, o;
        o = int'(off);
        n = (m[1:0] == 2'd0) ? 1 : (m[1:0] == 2'd1) ? 2 : 4;
        st = w;
        for (int k = 0; k < 4; k++)
            if (k >= o && k < o + n) st[8*k +: 8] = d[8*(k-o) +: 8];
    endfunction

    assign bus.mem_rdata = ld(mem[bus.mem_addr[7:2]], bus.mem_addr[1:0], bus.mem_mask);
    always @(negedge clk)
        if (bus.mem_wr_en) mem[bus.mem_addr[7:2]] = st(mem[bus.mem_addr[7:2]], bus.mem_wdata, bus.mem_addr[1:0], bus.mem_mask);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input bit we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        bus.req_valid[i]         = 1'b1;
        bus.req_we[i]            = we;
        bus.req_addr[32*i +: 32] = a;
        bus.req_wdata[32*i +: 32] = d;
        bus.req_mask[3*i +: 3]   = m;
    endtask

    task automatic rand_req(input int i);
        logic [2:0] m;
        int n;
        logic [31:0] a;
        m = lm[$urandom_range(4)];
        n = (m[1:0] == 2'd0) ? 1 : (m[1:0] == 2'd1) ? 2 : 4;
        a = ($urandom_range(63) << 2) + (n == 1 ? $urandom_range(3) : n == 2 ? 2 * $urandom_range(1) : 0);
        set_req(i, 1'($urandom_range(1)), a, $urandom, m);
    endtask

    // Sample at posedge+4, compare with the model, advance the model, return at next posedge+1.
    task automatic step();
        logic [NR-1:0] cand, er;
        int w;
        bit locked;
        #3;
        w = -1;
        er = '0;
        locked = 1'b0;
        cand = bus.req_valid;
`ifdef DMEM_ARB_LOCK_EN
        locked = lk && bus.req_lock[gid];
`endif
        if (locked) cand = cand & NR'(1 << gid);
        if (!reset && ph < 0)
            for (int k = 0; k < NR; k++)
                if (w < 0 && cand[(ptr + k) % NR]) w = (ptr + k) % NR;
        if (w >= 0) er[w] = 1'b1;
        seen = bus.req_ready;
        for (int i = 0; i < NR; i++) if (seen[i]) obs.push_back(i);
        if (bus.rsp_valid != '0) last_rd = bus.rsp_rdata;
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("rsp_valid", 32'(bus.rsp_valid), (!reset && ph == 2) ? 32'(1 << gid) : 32'h0);
        chk("rsp_rdata", bus.rsp_rdata, (!reset && ph == 2) ? exp_rd : 32'h0);
        chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(!reset && ph == 1 && c_we));
        chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(!reset && ph == 1 && !c_we));
        chk("mem_addr", bus.mem_addr, (!reset && ph == 1) ? c_addr : 32'h0);
        chk("mem_wdata", bus.mem_wdata, (!reset && ph == 1) ? c_wd : 32'h0);
        chk("mem_mask", 32'(bus.mem_mask), (!reset && ph == 1) ? 32'(c_mask) : 32'h0);
        chk("busy", 32'(bus.busy), 32'(ph >= 0));
        chk("grant_id", 32'(bus.grant_id), 32'(gid));
        if (reset) begin
            ph = -1; ptr = 0; gid = 0; lk = 1'b0;
        end else if (ph == 1) begin
            exp_rd = c_we ? 32'h0 : ld(ref_mem[c_addr[7:2]], c_addr[1:0], c_mask);
            if (c_we) ref_mem[c_addr[7:2]] = st(ref_mem[c_addr[7:2]], c_wd, c_addr[1:0], c_mask);
            ph = 2;
        end else if (ph == 2) begin
`ifdef DMEM_ARB_LOCK_EN
            lk = bus.req_lock[gid];
`endif
            ph = -1;
        end else begin
`ifdef DMEM_ARB_LOCK_EN
            if (!bus.req_lock[gid]) lk = 1'b0;
`endif
            if (w >= 0) begin
                c_we   = bus.req_we[w];
                c_addr = bus.req_addr[32*w +: 32];
                c_wd   = bus.req_wdata[32*w +: 32];
                c_mask = bus.req_mask[3*w +: 3];
                gid    = w;
                if (!locked) ptr = (w + 1) % NR;
                ph = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_mask  = '0;
`ifdef DMEM_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        last_rd = 32'h0;
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;
        // contention from reset: strict alternation, 3 cycles between accepts
        obs.delete();
        set_req(0, 1'b0, 32'h10, 32'h0, 3'b010);
        set_req(1, 1'b0, 32'h10, 32'h0, 3'b010);
        repeat (12) step();
        chk("cont_count", obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("cont_order", obs[i], i % 2);
        bus.req_valid = '0;
        repeat (3) step();
        // single load
        set_req(0, 1'b0, 32'h10, 32'h0, 3'b010);
        step();
        bus.req_valid = '0;
        repeat (3) step();
        chk("load_word", last_rd, 32'hDEADBEEF);
        // store byte, then unsigned byte load
        set_req(1, 1'b1, 32'h21, 32'h000000AB, 3'b000);
        step();
        bus.req_valid = '0;
        last_rd = 32'hFFFFFFFF;
        repeat (3) step();
        chk("store_rsp", last_rd, 32'h0);
        set_req(1, 1'b0, 32'h21, 32'h0, 3'b100);
        step();
        bus.req_valid = '0;
        repeat (3) step();
        chk("load_byte", last_rd, 32'h000000AB);
        // withdrawal during ACCESS
        obs.delete();
        set_req(0, 1'b0, 32'h40, 32'h0, 3'b010);
        step();
        bus.req_valid = '0;
        set_req(1, 1'b1, 32'h44, 32'h55, 3'b010);
        step();
        bus.req_valid = '0;
        repeat (3) step();
        chk("withdraw_grants", obs.size(), 1);
        // reset during a store ACCESS
        set_req(0, 1'b1, 32'h80, 32'h12345678, 3'b010);
        step();
        bus.req_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        obs.delete();
        set_req(0, 1'b0, 32'h80, 32'h0, 3'b010);
        set_req(1, 1'b0, 32'h84, 32'h0, 3'b010);
        step();
        bus.req_valid[0] = 1'b0;
        repeat (3) step();
        bus.req_valid = '0;
        repeat (3) step();
        chk("rst_count", obs.size(), 2);
        for (int i = 0; i < 2 && i < obs.size(); i++) chk("rst_order", obs[i], i);
`ifdef DMEM_ARB_LOCK_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        obs.delete();
        set_req(0, 1'b0, 32'h10, 32'h0, 3'b010);
        set_req(1, 1'b0, 32'h14, 32'h0, 3'b010);
        bus.req_lock[0] = 1'b1;
        repeat (7) step();
        bus.req_lock[0] = 1'b0;
        bus.req_valid[0] = 1'b0;
        repeat (5) step();
        bus.req_valid = '0;
        repeat (3) step();
        chk("lock_count", obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) chk("lock_order", obs[i], i == 3 ? 1 : 0);
`endif
        // random traffic with withdrawals and occasional resets
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(149) == 0);
            for (int i = 0; i < NR; i++) begin
                if (bus.req_valid[i] && (seen[i] || $urandom_range(19) == 0))
                    bus.req_valid[i] = 1'b0;
                else if (!bus.req_valid[i] && $urandom_range(2) == 0)
                    rand_req(i);
            end
            step();
        end
        reset = 1'b0;
        bus.req_valid = '0;
        repeat (4) step();
        for (int i = 0; i < 64; i++) chk("mem_contents", mem[i], ref_mem[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
